chunked_carry_adder: RTL and testbench

Parametrised multi-cycle binary adder. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and adds them CHUNK bits per clock, using a registered carry between slices. It returns sum, carry-out and signed overflow over a second valid/ready handshake. It is the datapath adder for wide operands where a full-width ripple chain would not meet timing.

---
 rtl/chunked_carry_adder_pkg.sv | 20 ++
 rtl/chunked_carry_adder_ripple.sv | 27 ++
 rtl/chunked_carry_adder.sv | 114 +++++++++++
 tb/tb_chunked_carry_adder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_carry_adder_pkg.sv
// Shared definitions for the chunked carry adder: FSM state encoding and
// sizing helpers for the chunk count and chunk-index registers.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter width for n values, never narrower than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_carry_adder_ripple.sv
// Combinational CHUNK-bit ripple-carry adder used for one slice per cycle.
module ripple_chunk_adder
  import adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[CHUNK];
  end

endmodule

// File: rtl/chunked_carry_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock with a registered carry,
// operands in and results out over valid/ready handshakes.
module chunked_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; the producer and
  // consumer sides are independent of each other.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = count_width(NCHUNK);
  localparam int IW     = count_width(WIDTH);

  generate
    if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("chunked_carry_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    count;
  logic [IW-1:0]    base;
  logic             last;
  logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout;

  assign base = IW'(int'(count) * CHUNK);
  assign last = (count == CW'(NCHUNK - 1));
  assign sl_a = op_a[base +: CHUNK];
  assign sl_b = op_b[base +: CHUNK];

  ripple_chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= a;
            op_b    <= b;
            carry_q <= cin;
            sum_q   <= '0;
            count   <= '0;
          end
        end
        RUN: begin
          sum_q[base +: CHUNK] <= sl_sum;
          carry_q              <= sl_cout;
          count                <= count + CW'(1);
          // The top slice carries the sign bit, so overflow is decided here.
          if (last) begin
            cout_q <= sl_cout;
            ovf_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (sl_sum[CHUNK-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_chunked_carry_adder.sv
// Bench for chunked_carry_adder: a 16/4 instance checked every cycle against an
// arithmetic model, plus an 8/8 single-chunk instance with directed checks.
module tb_chunked_carry_adder;
  import adder_pkg::*;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, sum;
  logic [1:0]  dbg16;

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, overflow8;
  logic [7:0]  a8, b8, sum8;
  logic [1:0]  dbg8;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_rst = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] last_res = '0;

  chunked_carry_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .dbg_state(dbg16)
  );

  chunked_carry_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .overflow(overflow8), .dbg_state(dbg8)
  );

  // Clock / reset
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Returns {overflow, cout, sum} for a w-bit add using plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic c);
    logic [32:0] t;
    logic [31:0] s;
    logic        co, ov;
    t  = {1'b0, x} + {1'b0, y} + {32'b0, c};
    s  = t[31:0] & ((32'h1 << w) - 32'h1);
    co = t[w];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    logic [33:0] m;
    m = model(16, {16'b0, x}, {16'b0, y}, c);
    return {m[33:32], m[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  // Scoreboard / compare process for the 16-bit instance
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
        chk("out_valid", 32'(out_valid),
            32'((exp_q.size() > 0) && (cyc - acc_cyc >= NCH + 1)));
        if (out_valid && exp_q.size() > 0)
          chk("result", {14'b0, overflow, cout, sum}, {14'b0, exp_q[0]});
      end
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          last_res = {overflow, cout, sum};
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model16(a, b, cin));
          acc_cyc = cyc;
        end
      end
      prev_rst = rst;
    end
  end

  // Driver tasks (all called and returning just after a rising edge)
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    bit got = 0;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) timeout("send");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    if (!got) timeout("wait_out_valid");
  endtask

  task automatic recv(input int hold);
    if (hold == 0) begin
      out_ready = 1'b1;
      wait_ov();
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      wait_ov();
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic check_reset_now(input string name);
    chk({name, "_state"}, 32'(dbg16), 32'(IDLE));
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_sum"}, 32'(sum), 32'd0);
  endtask

  // One transaction on the single-chunk instance; checks its one-cycle latency.
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      output logic [9:0] res);
    bit got = 0;
    a8 = xa; b8 = xb; cin8 = xc; in_valid8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready8) begin got = 1; break; end
    end
    if (!got) timeout("send8");
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_run_out_valid", 32'(out_valid8), 32'd0);
    chk("w8_run_in_ready", 32'(in_ready8), 32'd0);
    @(negedge clk);
    chk("w8_done_out_valid", 32'(out_valid8), 32'd1);
    res = {overflow8, cout8, sum8};
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    @(negedge clk);
    chk("w8_in_ready_after", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [9:0]  r8;
    logic [33:0] m8;
    logic [15:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_reset_now("init");
    chk("init_in_ready8", 32'(in_ready8), 32'd1);
    chk("init_out_valid8", 32'(out_valid8), 32'd0);

    send(16'h0000, 16'h0000, 1'b0); recv(1);
    chk("zero_ops", 32'(last_res), 32'h00000);
    send(16'hFFFF, 16'h0001, 1'b0); recv(0);
    chk("full_ripple", 32'(last_res), 32'h10000);
    send(16'h7FFF, 16'h0001, 1'b0); recv(2);
    chk("ovf_pos", 32'(last_res), 32'h28000);
    send(16'h8000, 16'h8000, 1'b0); recv(0);
    chk("ovf_neg", 32'(last_res), 32'h30000);

    // Backpressure with a competing operand offered while DONE
    send(16'h1234, 16'h4321, 1'b1);
    wait_ov();
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_sum", 32'(sum), 32'h5556);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_result", 32'(last_res), 32'h05556);
    send(16'hAAAA, 16'h5555, 1'b0); recv(0);
    chk("bp_next", 32'(last_res), 32'h0FFFF);

    // Reset in the second RUN cycle
    send(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_now("midrun");
    send(16'h0F0F, 16'h00F1, 1'b0); recv(1);
    chk("after_reset", 32'(last_res), 32'h01000);

    // Reset while DONE with out_ready high
    send(16'h4444, 16'h4444, 1'b0);
    wait_ov();
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b0;
    check_reset_now("done_rst");

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(ra, rb, 1'($urandom_range(0, 1)));
      recv($urandom_range(0, 3));
    end

    // Single-chunk configuration
    run8(8'hFF, 8'hFF, 1'b1, r8);
    chk("w8_ff_ff_c1", 32'(r8), 32'h1FF);
    for (int n = 0; n < 10; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      m8 = model(8, {24'b0, a8}, {24'b0, b8}, cin8);
      run8(a8, b8, cin8, r8);
      chk("w8_random", 32'(r8), 32'({m8[33:32], m8[7:0]}));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
